led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Multi-channel LED pattern generator. Each channel holds a 2-bit mode
//   (0 OFF, 1 ON, 2 BLINK, 3 BREATHE) and a tick divider. Channels are
//   programmed one at a time through a valid/ready write port. After each
//   accepted write the port is not ready for one cycle.
//
//   Optional feature macro: LED_PATTERN_BREATHE_EN
//     defined   -> shared PWM counter plus per-channel duty ramp; mode 3 breathes
//     undefined -> no PWM/duty logic; mode 3 behaves exactly like BLINK
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   cfg_valid  in   write request
//   cfg_ready  out  write can be accepted this cycle
//   cfg_chan   in   [CH_W]   target channel (>= CHANNELS: accepted, ignored)
//   cfg_mode   in   [2]      mode for the target channel
//   cfg_div    in   [DIV_W]  tick period in cycles, minus one
//   led        out  [CHANNELS] registered LED drives

module led_pattern_gen #(
    parameter int CHANNELS = 3,
    parameter int CH_W     = 2,
    parameter int DIV_W    = 16,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] led
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    // An illegal parameter set leaves the write port permanently not-ready,
    // so a bad instantiation shows up at the first configuration attempt.
    localparam bit CFG_OK = (CHANNELS >= 1) && (CHANNELS <= 16) &&
                            ((2 ** CH_W) >= CHANNELS) &&
                            (DIV_W >= 1) && (PWM_W >= 1);

    logic                ready_q;
    logic                accept;
    logic [CHANNELS-1:0] led_next;
    logic [CHANNELS-1:0] led_q;

    assign cfg_ready = ready_q & CFG_OK;
    assign accept    = cfg_valid & cfg_ready;
    assign led       = led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ~accept;
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic [PWM_W-1:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_W'(1);
        end
    end
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]       mode_q;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_q;
        logic             phase_q;
        logic             wr_hit;
        logic             tick;

        // Out-of-range channel numbers match no generate instance, so such
        // writes complete the handshake without touching any channel.
        assign wr_hit = accept && (cfg_chan == CH_W'(i));
        assign tick   = (cnt_q == div_q);

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q  <= MODE_OFF;
                div_q   <= '0;
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (wr_hit) begin
                mode_q  <= cfg_mode;
                div_q   <= cfg_div;
                cnt_q   <= '0;
                phase_q <= 1'b1;
            end else if (tick) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q   <= cnt_q + DIV_W'(1);
            end
        end

`ifdef LED_PATTERN_BREATHE_EN
        logic [PWM_W-1:0] duty_q;
        logic [PWM_W-1:0] duty_step;
        logic             dir_down_q;

        assign duty_step = dir_down_q ? (duty_q - PWM_W'(1)) : (duty_q + PWM_W'(1));

        // Direction flips on the tick that lands on an end value, so the ramp
        // turns around without ever wrapping.
        always_ff @(posedge clk) begin
            if (rst) begin
                duty_q     <= '0;
                dir_down_q <= 1'b0;
            end else if (wr_hit) begin
                duty_q     <= '0;
                dir_down_q <= 1'b0;
            end else if (tick) begin
                duty_q <= duty_step;
                if (duty_step == DUTY_MAX) begin
                    dir_down_q <= 1'b1;
                end else if (duty_step == '0) begin
                    dir_down_q <= 1'b0;
                end
            end
        end

        assign led_next[i] = (mode_q == MODE_ON)      ? 1'b1 :
                             (mode_q == MODE_BLINK)   ? phase_q :
                             (mode_q == MODE_BREATHE) ? (pwm_q < duty_q) :
                                                        1'b0;
`else
        assign led_next[i] = (mode_q == MODE_ON)      ? 1'b1 :
                             (mode_q == MODE_BLINK)   ? phase_q :
                             (mode_q == MODE_BREATHE) ? phase_q :
                                                        1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_next;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
//   Self-checking bench for led_pattern_gen (default parameters).
//   Expected LED vectors come from a per-channel table (mode, div, accept
//   cycle) and closed-form pattern equations; they are queued before each
//   clock edge and popped for comparison after it.

module tb_led_pattern_gen;

    localparam int CHANNELS = 3;
    localparam int CH_W     = 2;
    localparam int DIV_W    = 16;
    localparam int PWM_W    = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_chan = '0;
    logic [1:0]          cfg_mode = '0;
    logic [DIV_W-1:0]    cfg_div = '0;
    logic [CHANNELS-1:0] led;

    led_pattern_gen #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .DIV_W    (DIV_W),
        .PWM_W    (PWM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_div   (cfg_div),
        .led       (led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rst_cyc = 0;

    int m_mode [CHANNELS];
    int m_div  [CHANNELS];
    int m_acc  [CHANNELS];
    bit m_prev [CHANNELS];

    logic [CHANNELS-1:0] exp_q[$];
    logic                rdy_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected led bit of channel ch as seen after edge number c.
    function automatic bit exp_bit(int ch, int c);
        int k;
        k = c - m_acc[ch];
        if (k <= 0) return m_prev[ch];
        case (m_mode[ch])
            0:       return 1'b0;
            1:       return 1'b1;
            default: return (((k - 1) / (m_div[ch] + 1)) % 2) == 0;
        endcase
    endfunction

    function automatic logic [CHANNELS-1:0] exp_vec(int c);
        logic [CHANNELS-1:0] v;
        v = '0;
        for (int ch = 0; ch < CHANNELS; ch++) v[ch] = exp_bit(ch, c);
        return v;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            m_mode[ch] = 0;
            m_div[ch]  = 0;
            m_acc[ch]  = cyc;
            m_prev[ch] = 1'b0;
        end
        rst_cyc = cyc;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: cfg_ready=%b required 1", name, cfg_ready);
        end
    endtask

    task automatic do_write(input int ch, input int mode, input int div, input string name);
        bit prev;
        wait_ready(name);
        prev = (ch < CHANNELS) ? exp_bit(ch, cyc + 1) : 1'b0;
        cfg_valid = 1'b1;
        cfg_chan  = CH_W'(ch);
        cfg_mode  = 2'(mode);
        cfg_div   = DIV_W'(div);
        tick();
        cfg_valid = 1'b0;
        if (ch < CHANNELS) begin
            m_mode[ch] = mode;
            m_div[ch]  = div;
            m_acc[ch]  = cyc;
            m_prev[ch] = prev;
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after_accept: got %b required 0", name, cfg_ready);
        end
        checks++;
        if (led !== exp_vec(cyc)) begin
            errors++;
            $display("FAIL %s led_accept_cycle: got %b required %b", name, led, exp_vec(cyc));
        end
    endtask

    task automatic run_check(input int n, input string name);
        logic [CHANNELS-1:0] e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_vec(cyc + 1));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (led !== e) begin
                errors++;
                $display("FAIL %s led cycle %0d: got %b required %b", name, i, led, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (led !== '0) begin
            errors++;
            $display("FAIL reset_led: got %b required 000", led);
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", cfg_ready);
        end
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", cfg_ready);
        end
        run_check(4, "reset_idle");
    endtask

    task automatic test_on();
        do_write(0, 1, 0, "on_ch0");
        run_check(6, "on_ch0");
    endtask

    task automatic test_blink();
        do_write(1, 2, 3, "blink_ch1");
        run_check(24, "blink_ch1");
    endtask

    task automatic test_isolation();
        run_check(2, "iso_pre");
        do_write(2, 2, 1, "iso_ch2");
        run_check(16, "iso_run");
    endtask

    task automatic test_back_to_back();
        int accepted;
        bit prev;
        logic r;
        accepted = 0;
        wait_ready("b2b");
        rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
        cfg_valid = 1'b1;
        cfg_chan  = CH_W'(2);
        cfg_mode  = 2'd1;
        cfg_div   = '0;
        for (int i = 0; i < 6; i++) begin
            r = rdy_q.pop_front();
            checks++;
            if (cfg_ready !== r) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d: got %b required %b", i, cfg_ready, r);
            end
            prev = exp_bit(2, cyc + 1);
            if (cfg_ready === 1'b1) begin
                accepted++;
                tick();
                m_mode[2] = 1;
                m_div[2]  = 0;
                m_acc[2]  = cyc;
                m_prev[2] = prev;
            end else begin
                tick();
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (accepted !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes required 3", accepted);
        end
        run_check(6, "b2b_led");
    endtask

    task automatic test_bad_chan();
        do_write(1, 0, 0, "bad_prep_ch1_off");
        run_check(3, "bad_prep");
        do_write(3, 1, 0, "bad_chan3");
        run_check(100, "bad_chan3_hold");
    endtask

`ifndef LED_PATTERN_BREATHE_EN
    task automatic test_mode3_as_blink();
        do_write(1, 3, 2, "mode3_ch1");
        run_check(18, "mode3_ch1");
    endtask
`endif

    task automatic test_reset_mid();
        do_write(0, 2, 1, "rstmid_ch0");
        do_write(1, 2, 2, "rstmid_ch1");
        do_write(2, 2, 4, "rstmid_ch2");
        run_check(10, "rstmid_blink");
        wait_ready("rstmid");
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_chan  = CH_W'(0);
        cfg_mode  = 2'd1;
        cfg_div   = '0;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (led !== '0) begin
            errors++;
            $display("FAIL rstmid_led: got %b required 000", led);
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_low: got %b required 0", cfg_ready);
        end
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready_high: got %b required 1", cfg_ready);
        end
        run_check(10, "rstmid_discard");
    endtask

`ifdef LED_PATTERN_BREATHE_EN
    task automatic test_breathe();
        int e_cyc;
        int m;
        int d;
        int p;
        logic [CHANNELS-1:0] e;
        do_write(0, 3, 0, "breathe_ch0");
        e_cyc = cyc;
        for (int i = 0; i < 700; i++) begin
            m = (cyc - e_cyc) % 510;
            d = (m <= 255) ? m : (510 - m);
            p = (cyc - rst_cyc) % 256;
            e = '0;
            e[0] = (p < d);
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (led !== e) begin
                errors++;
                $display("FAIL breathe_ch0 cycle %0d: got %b required %b", i, led, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_on();
        test_blink();
        test_isolation();
        test_back_to_back();
        test_bad_chan();
`ifndef LED_PATTERN_BREATHE_EN
        test_mode3_as_blink();
`endif
        test_reset_mid();
`ifdef LED_PATTERN_BREATHE_EN
        test_breathe();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
